inst_fetch_ctrl: RTL and testbench

Fetch sequencer between the core's PC logic and the synchronous-read instruction memory. It owns the fetch PC, issues at most one memory read per cycle, and buffers returned words with their PCs in a small prefetch FIFO. It presents them to decode over a valid/ready handshake, and handles branch/jump redirects by squashing in-flight and buffered fetches.

---
 rtl/inst_fetch_ctrl_pkg.sv | 27 ++
 rtl/inst_fetch_ctrl_fifo.sv | 72 +++++++
 rtl/inst_fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch sequencer.
// Contents: data width, default reset PC and FIFO depth, the FSM state
// encoding, the FIFO entry payload (PC + instruction word), and a
// word-alignment helper.
package inst_fetch_ctrl_pkg;

  localparam int unsigned     XLEN             = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int unsigned     DEFAULT_DEPTH    = 2;
  localparam logic [XLEN-1:0] INST_BYTES       = 32'd4;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Clear the byte offset so every fetch address is word aligned.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/inst_fetch_ctrl_fifo.sv
// Prefetch FIFO holding fetched instruction words together with their PCs.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_push, i_wdata      write one entry (ignored when full without a pop)
//   i_pop                drop the head entry (ignored when empty)
//   i_flush              empty the FIFO; wins over push and pop
//   o_rdata              head entry, straight from the storage registers
//   o_count, o_full, o_empty  occupancy status
module inst_fetch_ctrl_fifo
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  fetch_entry_t            i_wdata,
  output fetch_entry_t            o_rdata,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full,
  output logic                    o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t   r_mem [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           w_do_push;
  logic           w_do_pop;

  assign o_count = r_count;
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rd_ptr];

  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage, pointers (wrap naturally modulo DEPTH) and occupancy.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer between the PC logic and a synchronous-read instruction
// memory. Owns the fetch PC, issues at most one read per cycle, buffers the
// returned words in a prefetch FIFO and hands them to decode via valid/ready.
// Redirects flush the FIFO and squash the outstanding fetch.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   o_imem_req, o_imem_addr        memory read request (combinational) / address
//   i_imem_rdata                   read data, one cycle after the request
//   o_inst_valid, o_inst, o_inst_pc  FIFO head towards decode
//   i_inst_ready                   decode accepts the head
//   i_redirect, i_redirect_pc      refetch from a new address
//   i_halt                         stop issuing new requests
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned     DEPTH    = DEFAULT_DEPTH
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [XLEN-1:0] o_imem_addr,
  input  logic [XLEN-1:0] i_imem_rdata,
  output logic            o_inst_valid,
  output logic [XLEN-1:0] o_inst,
  output logic [XLEN-1:0] o_inst_pc,
  input  logic            i_inst_ready,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_halt
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  fetch_state_e    r_state;
  fetch_state_e    w_state_nxt;
  logic [XLEN-1:0] r_fpc;
  logic [XLEN-1:0] r_req_pc;
  logic            r_inflight;
  logic            r_squash;
  logic            w_req;
  logic            w_pop;
  logic            w_push;
  logic            w_empty;
  logic            w_full_unused;
  logic [CW-1:0]   w_count;
  logic [OW-1:0]   w_occ;
  fetch_entry_t    w_wdata;
  fetch_entry_t    w_head;

  assign w_pop  = o_inst_valid && i_inst_ready;
  assign w_push = r_inflight && !r_squash;
  // Slots that will be taken once the outstanding response lands.
  assign w_occ  = OW'(w_count) + OW'(r_inflight) - OW'(w_pop);

  assign w_wdata.pc   = r_req_pc;
  assign w_wdata.inst = i_imem_rdata;

  assign o_imem_req   = w_req;
  assign o_imem_addr  = r_fpc;
  assign o_inst_valid = !w_empty;
  assign o_inst       = w_head.inst;
  assign o_inst_pc    = w_head.pc;

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: BOOT is a single idle cycle, then RUN forever.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // Issue decision.
  always_comb begin
    w_req = 1'b0;
    if (r_state == ST_RUN && !i_halt && !i_redirect && (w_occ < OW'(DEPTH))) begin
      w_req = 1'b1;
    end
  end

  // Fetch PC, outstanding-request tracking and squash flag.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fpc      <= word_align(RESET_PC);
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_squash   <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) begin
        r_req_pc <= r_fpc;
      end
      if (i_redirect) begin
        r_fpc    <= word_align(i_redirect_pc);
        r_squash <= r_inflight;
      end else begin
        // Squash covers only the single response slot after a redirect.
        r_squash <= 1'b0;
        if (w_req) begin
          r_fpc <= r_fpc + INST_BYTES;
        end
      end
    end
  end

  inst_fetch_ctrl_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (i_redirect),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full_unused),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Self-checking bench for inst_fetch_ctrl: a memory model answers every
// request one cycle later, a scoreboard queue holds the expected PC/word
// stream and a monitor compares every accepted instruction against it.
module tb_inst_fetch_ctrl;
  import inst_fetch_ctrl_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;

  int n_checks = 0;
  int n_pass   = 0;
  int n_accept = 0;

  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;

  inst_fetch_ctrl #(
    .RESET_PC (RESET_PC),
    .DEPTH    (2)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_rdata  (imem_rdata),
    .o_inst_valid  (inst_valid),
    .o_inst        (inst),
    .o_inst_pc     (inst_pc),
    .i_inst_ready  (inst_ready),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_halt        (halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: upper half reads as zero, otherwise a word tagged by address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31]) return 32'h0;
    return 32'h0000_0013 | {a[26:2], 7'b0};
  endfunction

  // Synchronous-read memory; garbage when no request was made.
  always @(posedge clk) imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  // Expected stream restarts at a new PC (after reset or redirect).
  task automatic sb_restart(input logic [31:0] pc);
    fetch_entry_t e;
    logic [31:0]  p;
    exp_q.delete();
    p = pc & 32'hFFFF_FFFC;
    for (int i = 0; i < 128; i++) begin
      e.pc   = p;
      e.inst = mem_word(p);
      exp_q.push_back(e);
      p = p + 32'd4;
    end
  endtask

  // Scoreboard: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready) begin
      n_checks++;
      n_accept++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_empty: got pc %h inst %h, expected no delivery", inst_pc, inst);
      end else begin
        mon_e = exp_q.pop_front();
        if (inst_pc !== mon_e.pc || inst !== mon_e.inst)
          $display("FAIL sb_stream: got pc %h inst %h, expected pc %h inst %h",
                   inst_pc, inst, mon_e.pc, mon_e.inst);
        else n_pass++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      assert (!(dut.w_push && dut.u_fifo.o_full && !dut.w_pop))
        else $error("push into full prefetch buffer");
      if (imem_req) assert (imem_addr[1:0] == 2'b00) else $error("unaligned request");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC)
      $display("FAIL reset_req: got req %b addr %h, expected 0 %h", imem_req, imem_addr, RESET_PC);
    else n_pass++;
    n_checks++;
    if ({inst_valid, inst, inst_pc} !== 65'b0)
      $display("FAIL reset_out: got valid %b inst %h pc %h, expected all zero", inst_valid, inst, inst_pc);
    else n_pass++;
    tick(); tick();
    sb_restart(RESET_PC);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL boot_req: got %b expected 0", imem_req);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL first_req: got req %b addr %h, expected 1 %h", imem_req, imem_addr, RESET_PC);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if (inst_valid !== 1'b0) $display("FAIL cycle2_valid: got %b expected 0", inst_valid);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== RESET_PC || inst !== 32'h0000_0013)
      $display("FAIL cycle3_valid: got valid %b pc %h inst %h, expected 1 %h 00000013",
               inst_valid, inst_pc, inst, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 8; i++) begin
      tick(); #1;
      n_checks++;
      if (inst_valid !== 1'b1 || imem_req !== 1'b1)
        $display("FAIL stream_bubble: cycle %0d got valid %b req %b, expected 1 1", i, inst_valid, imem_req);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    tick(); inst_ready = 1'b0; #1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin tick(); #1; end
      n_checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b1)
        $display("FAIL stall_req: stall %0d got req %b valid %b, expected 0 1", i, imem_req, inst_valid);
      else n_pass++;
      if (i > 0) begin
        n_checks++;
        if (dut.u_fifo.o_count !== 2'd2)
          $display("FAIL stall_count: stall %0d got %0d expected 2", i, dut.u_fifo.o_count);
        else n_pass++;
      end
    end
    tick(); inst_ready = 1'b1; #1;
    n_checks++;
    if (imem_req !== 1'b1) $display("FAIL resume_req: got %b expected 1", imem_req);
    else n_pass++;
  endtask

  task automatic test_redirect();
    tick(); redirect = 1'b1; redirect_pc = 32'h0000_0103; #1;
    n_checks++;
    if (dut.r_inflight !== 1'b1 || imem_req !== 1'b0)
      $display("FAIL redir_cycle: got inflight %b req %b, expected 1 0", dut.r_inflight, imem_req);
    else n_pass++;
    tick(); redirect = 1'b0; sb_restart(32'h0000_0103); #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0100 || inst_valid !== 1'b0)
      $display("FAIL redir_r1: got req %b addr %h valid %b, expected 1 00000100 0",
               imem_req, imem_addr, inst_valid);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if (inst_valid !== 1'b0) $display("FAIL redir_r2: got valid %b expected 0", inst_valid);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h0000_0100)
      $display("FAIL redir_r3: got valid %b pc %h, expected 1 00000100", inst_valid, inst_pc);
    else n_pass++;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_wrap();
    logic [31:0] tgt;
    logic [31:0] first_inst;
    for (int k = 0; k < 2; k++) begin
      tgt        = (k == 0) ? 32'hFFFF_FFF8 : 32'h8000_0000;
      first_inst = 32'h0;
      tick(); redirect = 1'b1; redirect_pc = tgt; #1;
      tick(); redirect = 1'b0; sb_restart(tgt); #1;
      tick(); tick(); #1;
      n_checks++;
      if (inst_valid !== 1'b1 || inst_pc !== tgt || inst !== first_inst)
        $display("FAIL wrap_first: got valid %b pc %h inst %h, expected 1 %h %h",
                 inst_valid, inst_pc, inst, tgt, first_inst);
      else n_pass++;
      if (k == 0) begin
        tick(); tick(); #1;
        n_checks++;
        if (inst_pc !== 32'h0 || inst !== 32'h0000_0013)
          $display("FAIL wrap_zero: got pc %h inst %h, expected 00000000 00000013", inst_pc, inst);
        else n_pass++;
      end
    end
    tick(); tick();
  endtask

  task automatic test_halt();
    tick(); halt = 1'b1; #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL halt_req: got %b expected 0", imem_req);
    else n_pass++;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_checks++;
      if (inst_valid !== 1'b0 || imem_req !== 1'b0)
        $display("FAIL halt_drain: cycle %0d got valid %b req %b, expected 0 0", i, inst_valid, imem_req);
      else n_pass++;
    end
    tick(); halt = 1'b0; #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== exp_q[0].pc)
      $display("FAIL halt_resume: got req %b addr %h, expected 1 %h", imem_req, imem_addr, exp_q[0].pc);
    else n_pass++;
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_reset_midflight();
    tick(); #1;
    n_checks++;
    if (imem_req !== 1'b1) $display("FAIL pre_reset_req: got %b expected 1", imem_req);
    else n_pass++;
    tick(); #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || imem_addr !== RESET_PC || {inst_valid, inst, inst_pc} !== 65'b0)
      $display("FAIL async_reset: got req %b addr %h valid %b inst %h pc %h, expected 0 %h 0 0 0",
               imem_req, imem_addr, inst_valid, inst, inst_pc, RESET_PC);
    else n_pass++;
    tick(); tick();
    sb_restart(RESET_PC);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b0) $display("FAIL reboot_req: got %b expected 0", imem_req);
    else n_pass++;
    tick(); #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC)
      $display("FAIL reboot_first: got req %b addr %h, expected 1 %h", imem_req, imem_addr, RESET_PC);
    else n_pass++;
    tick(); tick(); #1;
    n_checks++;
    if (inst_valid !== 1'b1 || inst_pc !== RESET_PC)
      $display("FAIL reboot_valid: got valid %b pc %h, expected 1 %h", inst_valid, inst_pc, RESET_PC);
    else n_pass++;
    for (int i = 0; i < 6; i++) tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_reset_midflight();
    n_checks++;
    if (n_accept < 30) $display("FAIL accept_total: got %0d expected at least 30", n_accept);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
